// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one SPI core's TX/RX FIFO pair between NREQ requesters.
// Each grant pushes one TX word, waits (bounded) for the matching RX word and returns it.
module spi_xfer_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               SPE,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ*DW-1:0] REQ_DATA,
    output logic [NREQ-1:0]    GNT,
    output logic [NREQ-1:0]    DONE,
    output logic [DW-1:0]      RSP_DATA,
    output logic               TIMEOUT_ERR,
    output logic               BUSY,
    input  logic               TX_FULL,
    output logic               TX_WR_EN,
    output logic [DW-1:0]      TX_DATA,
    input  logic               RX_EMPTY,
    output logic               RX_RD_EN,
    input  logic [DW-1:0]      RX_DATA
);

    // state     | meaning
    // S_IDLE    | waiting for SPE and a request; round-robin pick
    // S_PUSH    | write granted word into TX FIFO once it has room
    // S_WAIT_RX | wait for the reply word, bounded by TIMEOUT cycles
    // S_CAPTURE | popped word is on RX_DATA; latch it
    // S_RESP    | DONE pulse to the granted requester
    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_WAIT_RX,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr, idx, pick_idx;
    logic            pick_vld;
    logic [TW-1:0]   timer;
    logic            timer_tc;
    logic [DW-1:0]   req_word [NREQ];

    assign timer_tc = (timer == T_LAST);

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_word[i] = REQ_DATA[i*DW +: DW];
        end
    end

    // Scan from farthest to nearest so the nearest set bit after rr_ptr wins.
    always_comb begin
        int c;
        logic [IW-1:0] cand;
        c        = 0;
        cand     = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            c = int'(rr_ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            cand = IW'(c);
            if (REQ[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (SPE && pick_vld) state_nxt = S_PUSH;
            S_PUSH:    if (!TX_FULL) state_nxt = S_WAIT_RX;
            S_WAIT_RX: begin
                if (!RX_EMPTY)     state_nxt = S_CAPTURE;
                else if (timer_tc) state_nxt = S_RESP;
            end
            S_CAPTURE: state_nxt = S_RESP;
            S_RESP:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Strobes are gated by the live FIFO flags so they can never hit a full/empty FIFO.
    always_comb begin
        TX_WR_EN = 1'b0;
        RX_RD_EN = 1'b0;
        if (state == S_PUSH && !TX_FULL)     TX_WR_EN = 1'b1;
        if (state == S_WAIT_RX && !RX_EMPTY) RX_RD_EN = 1'b1;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rr_ptr      <= IW'(NREQ - 1);
            idx         <= '0;
            timer       <= '0;
            GNT         <= '0;
            DONE        <= '0;
            RSP_DATA    <= '0;
            TIMEOUT_ERR <= 1'b0;
            BUSY        <= 1'b0;
            TX_DATA     <= '0;
        end else begin
            DONE <= '0;
            BUSY <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_PUSH) begin
                        idx     <= pick_idx;
                        TX_DATA <= req_word[pick_idx];
                        GNT     <= GNT_ONE << pick_idx;
                    end
                end
                S_PUSH: begin
                    if (!TX_FULL) timer <= '0;
                end
                S_WAIT_RX: begin
                    if (RX_EMPTY) begin
                        if (timer_tc) begin
                            RSP_DATA    <= '1;
                            TIMEOUT_ERR <= 1'b1;
                            DONE        <= GNT_ONE << idx;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                S_CAPTURE: begin
                    RSP_DATA <= RX_DATA;
                    DONE     <= GNT_ONE << idx;
                end
                S_RESP: begin
                    GNT         <= '0;
                    RSP_DATA    <= '0;
                    TIMEOUT_ERR <= 1'b0;
                    rr_ptr      <= idx;
                end
                default: ;
            endcase
        end
    end

endmodule
